rgb_frame_ctrl: RTL and testbench

Sequencing controller between the `rgb_sinp` serial-input decoder and the RGB→RGBW conversion datapath. It consumes the decoded bit stream (`out`/`strobe`/`stream_reset`), frames it into 24-bit pixel words and numbers them per frame. It hands words downstream through a 2-entry valid/ready buffer and reports frame boundaries and framing errors.

---
 rtl/rgb_frame_ctrl_pkg.sv | 14 +
 rtl/rgb_pix_fifo.sv | 68 ++++++
 rtl/rgb_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_rgb_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_frame_ctrl_pkg.sv
// Shared definitions for the RGB frame sequencing controller: default
// pixel word size and the controller state encoding.
package rgb_frame_ctrl_pkg;

  localparam int BITS_PER_PIXEL_DEF = 24;

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_SATURATED = 2'd3
  } frame_state_e;

endpackage

// File: rtl/rgb_pix_fifo.sv
// Two-entry pixel buffer with registered head; a push into a full buffer
// is accepted only when a pop happens in the same cycle.
module rgb_pix_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       cnt_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = pop & (cnt_r != 2'd0);
  assign do_push_s = push & ((cnt_r != 2'd2) | do_pop_s);

  assign head  = head_r;
  assign valid = (cnt_r != 2'd0);
  assign full  = (cnt_r == 2'd2);

  // Storage update: head always holds the oldest entry, tail the newer one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case (cnt_r)
        2'd0: begin
          if (do_push_s) begin
            head_r <= push_data;
            cnt_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push_s && do_pop_s) begin
            head_r <= push_data;
          end else if (do_pop_s) begin
            cnt_r <= 2'd0;
          end else if (do_push_s) begin
            tail_r <= push_data;
            cnt_r  <= 2'd2;
          end
        end
        2'd2: begin
          if (do_pop_s) begin
            head_r <= tail_r;
            if (do_push_s) begin
              tail_r <= push_data;
            end else begin
              cnt_r <= 2'd1;
            end
          end
        end
        default: cnt_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/rgb_frame_ctrl.sv
// Frames the decoded serial bit stream into numbered pixel words, buffers
// them for the downstream converter and reports frame boundaries/errors.
module rgb_frame_ctrl
  import rgb_frame_ctrl_pkg::*;
#(
  parameter int BITS_PER_PIXEL = BITS_PER_PIXEL_DEF,
  parameter int MAX_PIXELS     = 256,
  parameter int PIX_IDX_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_strobe,
  input  logic                      stream_reset,
  output logic [BITS_PER_PIXEL-1:0] pix_data,
  output logic [PIX_IDX_W-1:0]      pix_idx,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic [PIX_IDX_W:0]        frame_pix_cnt,
  output logic                      err_overflow,
  output logic                      err_partial
);

  localparam int BIT_CNT_W = $clog2(BITS_PER_PIXEL);
  localparam int FIFO_W    = BITS_PER_PIXEL + PIX_IDX_W;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
  localparam logic [PIX_IDX_W:0]   PIX_MAX  = (PIX_IDX_W + 1)'(MAX_PIXELS);
  localparam logic [PIX_IDX_W:0]   PIX_ONE  = (PIX_IDX_W + 1)'(1);

  frame_state_e              state_r;
  logic                      sr_prev_r;
  logic [BITS_PER_PIXEL-2:0] shift_r;
  logic [BIT_CNT_W-1:0]      bit_cnt_r;
  logic [PIX_IDX_W:0]        pix_cnt_r;
  logic                      frame_start_r;
  logic                      frame_done_r;
  logic [PIX_IDX_W:0]        frame_pix_cnt_r;
  logic                      err_overflow_r;
  logic                      err_partial_r;

  logic                      sr_rise_s;
  logic                      acc_s;
  logic                      push_s;
  logic [FIFO_W-1:0]         push_word_s;
  logic [FIFO_W-1:0]         fifo_head_s;
  logic                      fifo_full_s;
  logic                      fifo_valid_s;

  // A strobe during the line-idle period never carries pixel data.
  assign sr_rise_s   = stream_reset & ~sr_prev_r;
  assign acc_s       = bit_strobe & ~stream_reset;
  assign push_s      = (state_r == ST_ACTIVE) & acc_s & (bit_cnt_r == LAST_BIT);
  assign push_word_s = {shift_r, bit_in, pix_cnt_r[PIX_IDX_W-1:0]};

  rgb_pix_fifo #(
    .WIDTH(FIFO_W)
  ) u_pix_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pix_ready),
    .head      (fifo_head_s),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s)
  );

  assign pix_data      = fifo_head_s[FIFO_W-1 -: BITS_PER_PIXEL];
  assign pix_idx       = fifo_head_s[PIX_IDX_W-1:0];
  assign pix_valid     = fifo_valid_s;
  assign frame_start   = frame_start_r;
  assign frame_done    = frame_done_r;
  assign frame_pix_cnt = frame_pix_cnt_r;
  assign err_overflow  = err_overflow_r;
  assign err_partial   = err_partial_r;

  // Framing state machine with its registered pulses and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_SYNC;
      sr_prev_r       <= 1'b0;
      shift_r         <= '0;
      bit_cnt_r       <= '0;
      pix_cnt_r       <= '0;
      frame_start_r   <= 1'b0;
      frame_done_r    <= 1'b0;
      frame_pix_cnt_r <= '0;
      err_overflow_r  <= 1'b0;
      err_partial_r   <= 1'b0;
    end else begin
      sr_prev_r     <= stream_reset;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      if (push_s && fifo_full_s && !pix_ready) begin
        err_overflow_r <= 1'b1;
      end
      case (state_r)
        ST_SYNC: begin
          if (sr_rise_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (acc_s) begin
            state_r       <= ST_ACTIVE;
            shift_r       <= (BITS_PER_PIXEL - 1)'(bit_in);
            bit_cnt_r     <= BIT_ONE;
            pix_cnt_r     <= '0;
            frame_start_r <= 1'b1;
          end
        end
        ST_ACTIVE, ST_SATURATED: begin
          if (sr_rise_s) begin
            state_r         <= ST_IDLE;
            frame_done_r    <= 1'b1;
            frame_pix_cnt_r <= pix_cnt_r;
            bit_cnt_r       <= '0;
            if (bit_cnt_r != '0) begin
              err_partial_r <= 1'b1;
            end
          end else if (acc_s && (state_r == ST_ACTIVE)) begin
            // A dropped word still consumes its index so the gap is visible.
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              pix_cnt_r <= pix_cnt_r + PIX_ONE;
              if ((pix_cnt_r + PIX_ONE) == PIX_MAX) begin
                state_r <= ST_SATURATED;
              end
            end else begin
              shift_r   <= {shift_r[BITS_PER_PIXEL-3:0], bit_in};
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end
        end
        default: state_r <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_frame_ctrl.sv
// Bench for rgb_frame_ctrl: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model of the framing rules.
module tb_rgb_frame_ctrl;

  localparam int BPP  = 24;
  localparam int MAXP = 4;
  localparam int IW   = 8;

  logic          clk;
  logic          rst;
  logic          bit_in;
  logic          bit_strobe;
  logic          stream_reset;
  logic [BPP-1:0] pix_data;
  logic [IW-1:0] pix_idx;
  logic          pix_valid;
  logic          pix_ready;
  logic          frame_start;
  logic          frame_done;
  logic [IW:0]   frame_pix_cnt;
  logic          err_overflow;
  logic          err_partial;

  rgb_frame_ctrl #(
    .BITS_PER_PIXEL(BPP),
    .MAX_PIXELS    (MAXP),
    .PIX_IDX_W     (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_in        (bit_in),
    .bit_strobe    (bit_strobe),
    .stream_reset  (stream_reset),
    .pix_data      (pix_data),
    .pix_idx       (pix_idx),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .frame_pix_cnt (frame_pix_cnt),
    .err_overflow  (err_overflow),
    .err_partial   (err_partial)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int dut_fd_cnt = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: framing described as "bits pending" / "pixels so far".
  bit          m_synced, m_in_frame, m_sr_prev, m_ovf, m_part, m_fs, m_fd;
  int          m_pix, m_nbits, m_fpc, m_fd_cnt;
  logic [23:0] m_word;
  logic [31:0] m_q[$];
  logic [31:0] m_log[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_synced = 1'b0; m_in_frame = 1'b0; m_sr_prev = 1'b0;
    m_ovf = 1'b0; m_part = 1'b0; m_fs = 1'b0; m_fd = 1'b0;
    m_pix = 0; m_nbits = 0; m_fpc = 0; m_word = 24'h0;
    m_q.delete();
  endfunction

  task automatic model_step();
    bit          pop, sr_rise, acc, push;
    logic [31:0] pw;
    if (rst) begin
      model_reset();
      return;
    end
    m_fs = 1'b0;
    m_fd = 1'b0;
    push = 1'b0;
    pw = 32'h0;
    pop = (m_q.size() > 0) && pix_ready;
    sr_rise = stream_reset && !m_sr_prev;
    acc = bit_strobe && !stream_reset;
    if (!m_synced) begin
      if (sr_rise) m_synced = 1'b1;
    end else if (sr_rise) begin
      if (m_in_frame) begin
        m_fd = 1'b1;
        m_fd_cnt++;
        m_fpc = m_pix;
        if (m_nbits != 0) m_part = 1'b1;
        m_nbits = 0;
        m_in_frame = 1'b0;
      end
    end else if (acc) begin
      if (!m_in_frame) begin
        m_in_frame = 1'b1;
        m_fs = 1'b1;
        m_pix = 0;
        m_nbits = 0;
        m_word = 24'h0;
      end
      if (m_pix < MAXP) begin
        m_word = {m_word[22:0], bit_in};
        m_nbits++;
        if (m_nbits == BPP) begin
          push = 1'b1;
          pw = {m_word, 8'(m_pix)};
          m_pix++;
          m_nbits = 0;
        end
      end
    end
    if (pop) m_log.push_back(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(pw);
      else m_ovf = 1'b1;
    end
    m_sr_prev = stream_reset;
  endtask

  initial begin
    model_reset();
    m_fd_cnt = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        if (frame_done === 1'b1) dut_fd_cnt++;
        chk("pix_valid", pix_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          chk("pix_data", pix_data, m_q[0][31:8]);
          chk("pix_idx", pix_idx, m_q[0][7:0]);
        end
        chk("frame_start", frame_start, m_fs);
        chk("frame_done", frame_done, m_fd);
        chk("frame_pix_cnt", frame_pix_cnt, m_fpc);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_partial", err_partial, m_part);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input logic b, input logic s, input logic sr, input logic rdy);
    @(negedge clk);
    bit_in = b; bit_strobe = s; stream_reset = sr; pix_ready = rdy;
    @(posedge clk);
    #3;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0, rdy);
      if (i % 3 == 0) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic sr_pulse(input logic rdy, input logic strobe_on_rise);
    cyc(1'b1, strobe_on_rise, 1'b1, rdy);
    cyc(1'b0, 1'b1, 1'b1, rdy);
    cyc(1'b0, 1'b0, 1'b1, rdy);
    cyc(1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    int L, fd0;
    rst = 1'b1; bit_in = 1'b0; bit_strobe = 1'b0; stream_reset = 1'b0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(posedge clk); #3;
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_data", pix_data, 24'h0);
    chk("rst_frame_pix_cnt", frame_pix_cnt, 9'h0);
    @(negedge clk) rst = 1'b0;

    // Pre-sync strobes are ignored, then sync and one pixel.
    send_bits(32'h3FF, 10, 1'b0);
    sr_pulse(1'b0, 1'b0);
    chk("presync_nothing", pix_valid, 1'b0);
    send_bits(32'h00A5C3F0, 24, 1'b0);
    chk("t1_valid", pix_valid, 1'b1);
    chk("t1_data", pix_data, 24'hA5C3F0);
    chk("t1_idx", pix_idx, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_model_word", m_log[0], {24'hA5C3F0, 8'd0});
    sr_pulse(1'b1, 1'b0);
    chk("t1_fpc", frame_pix_cnt, 9'd1);

    // Three pixels with a free-flowing sink.
    L = m_log.size(); fd0 = dut_fd_cnt;
    send_bits(32'h000001, 24, 1'b1);
    send_bits(32'hFFFFFF, 24, 1'b1);
    send_bits(32'h800000, 24, 1'b1);
    sr_pulse(1'b1, 1'b0);
    chk("t2_model_w0", m_log[L],     {24'h000001, 8'd0});
    chk("t2_model_w1", m_log[L + 1], {24'hFFFFFF, 8'd1});
    chk("t2_model_w2", m_log[L + 2], {24'h800000, 8'd2});
    chk("t2_fpc", frame_pix_cnt, 9'd3);
    chk("t2_fd_count", dut_fd_cnt - fd0, 1);

    // Stalled sink: two buffered, two dropped.
    L = m_log.size();
    send_bits(32'hAAAAAA, 24, 1'b0);
    send_bits(32'h555555, 24, 1'b0);
    send_bits(32'h123456, 24, 1'b0);
    send_bits(32'h654321, 24, 1'b0);
    chk("t3_overflow", err_overflow, 1'b1);
    chk("t3_head", pix_data, 24'hAAAAAA);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drained", pix_valid, 1'b0);
    chk("t3_model_w0", m_log[L],     {24'hAAAAAA, 8'd0});
    chk("t3_model_w1", m_log[L + 1], {24'h555555, 8'd1});
    chk("t3_model_cnt", m_log.size() - L, 2);
    sr_pulse(1'b1, 1'b0);
    chk("t3_fpc", frame_pix_cnt, 9'd4);
    send_bits(32'h0F0F0F, 24, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_restart_idx", m_log[m_log.size() - 1], {24'h0F0F0F, 8'd0});
    sr_pulse(1'b1, 1'b0);

    // 30 bits then close, with a strobe on the rising edge of stream_reset.
    chk("t4_partial_before", err_partial, 1'b0);
    send_bits(32'h00C3C3C3, 24, 1'b1);
    send_bits(32'h3F, 6, 1'b1);
    sr_pulse(1'b1, 1'b1);
    chk("t4_partial", err_partial, 1'b1);
    chk("t4_fpc", frame_pix_cnt, 9'd1);

    // Six pixels into a four-pixel frame.
    L = m_log.size();
    for (int p = 0; p < 6; p++) send_bits(32'h111111 * (p + 1), 24, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_count", m_log.size() - L, 4);
    chk("t5_last", m_log[L + 3], {24'h444444, 8'd3});
    sr_pulse(1'b1, 1'b0);
    chk("t5_fpc", frame_pix_cnt, 9'd4);

    // Reset mid-frame with a word buffered.
    send_bits(32'hC0FFEE, 24, 1'b0);
    send_bits(32'hABC, 12, 1'b0);
    fd0 = dut_fd_cnt;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #3;
    chk("t6_valid", pix_valid, 1'b0);
    chk("t6_data", pix_data, 24'h0);
    chk("t6_idx", pix_idx, 8'h0);
    chk("t6_fpc", frame_pix_cnt, 9'h0);
    chk("t6_ovf", err_overflow, 1'b0);
    chk("t6_part", err_partial, 1'b0);
    @(negedge clk) rst = 1'b0;
    send_bits(32'h123456, 24, 1'b1);
    chk("t6_needs_sync", pix_valid, 1'b0);
    chk("t6_no_done", dut_fd_cnt - fd0, 0);
    sr_pulse(1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 1999) == 0);
      bit_in       = 1'($urandom_range(0, 1));
      bit_strobe   = ($urandom_range(0, 9) < 6);
      pix_ready    = ($urandom_range(0, 9) < 6);
      if (stream_reset) stream_reset = ($urandom_range(0, 3) != 0);
      else stream_reset = ($urandom_range(0, 149) == 0);
      @(posedge clk); #3;
    end
    @(negedge clk);
    rst = 1'b0; bit_strobe = 1'b0; stream_reset = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
